adsr_envelope: RTL and testbench
================================

# adsr_envelope

Amplitude envelope stage placed directly downstream of the waveform shape selector. Per sample tick it advances an ADSR (attack/decay/sustain/release) state machine driven by a note gate and multiplies the selected 16-bit waveform sample by the 16-bit envelope level. The scaled sample then goes to the mixer/DAC path.

## Interface
Parameters:
- `DW`, 16, sample width (signed two's complement).
- `LW`, 16, envelope level width (unsigned; full scale `0xFFFF`).

Ports:
- `Clk`  in  1  system clock.
- `Reset`  in  1  synchronous, active-high reset.
- `sample_tick`  in  1  one-cycle strobe at the audio sample rate; aligned with a valid `sample_in`.
- `gate`  in  1  note held (1) / released (0).
- `sample_in`  in  DW  signed waveform sample from the shape selector.
- `attack_rate`  in  LW  per-tick level increment in ATTACK.
- `decay_rate`  in  LW  per-tick level decrement in DECAY.
- `sustain_level`  in  LW  sustain target level.
- `release_rate`  in  LW  per-tick level decrement in RELEASE.
- `sample_out`  out  DW  signed scaled sample.
- `sample_valid`  out  1  one-cycle pulse; `sample_out` is new.
- `active`  out  1  high whenever state is not IDLE.
- `level`  out  LW  current envelope level (for debug and metering).

## Operation
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. All state and level updates happen only on cycles where `sample_tick=1`.
- `gate` is sampled only on tick cycles. `gate_q` holds the gate value from the previous tick. A rise is `gate & ~gate_q`; a fall is `~gate & gate_q`.
- Gate rise in any state: enter ATTACK. `level` keeps its current value and is not zeroed (retrigger without click).
- Gate fall in ATTACK, DECAY or SUSTAIN: enter RELEASE.
- If rise or fall applies on a tick, that tick performs only the state change. `level` is unchanged on that tick.
- ATTACK: `level += attack_rate`.
  - If the sum is at least `0xFFFF` (compute with a 17-bit sum), `level` becomes `0xFFFF` and the state moves to DECAY.
  - `attack_rate=0` sets `level` to `0xFFFF` immediately.
- DECAY: `level -= decay_rate`.
  - If the result is at or below `sustain_level`, or would underflow, `level` becomes `sustain_level` and the state moves to SUSTAIN.
  - `decay_rate=0` jumps directly to `sustain_level`.
- SUSTAIN: `level` follows `sustain_level` every tick, so live changes take effect.
- RELEASE: `level -= release_rate`.
  - If the result is at or below 0, `level` becomes 0 and the state moves to IDLE.
  - `release_rate=0` jumps directly to 0.
- IDLE: `level` is 0.
- Scaling: `product = sample_in * $signed({1'b0, level})` (33-bit signed), then `sample_out = product[31:16]` (arithmetic, floor).
  - Example: `0x4000` at level `0xFFFF` gives `0x3FFF`.
  - Example: `0x8000` at level `0xFFFF` gives `0x8000`.
  - Any sample at level 0 gives 0.
- Reset values: state IDLE, `level=0`, `gate_q=0`, `sample_out=0`, `sample_valid=0`, `active=0`, pipeline registers 0.

## Timing
- Tick at cycle T:
  - Stage 1 (edge ending T): `sample_in` is captured and `level`/state are updated.
  - Stage 2 (next edge): the product of the captured sample and the updated level is registered into `sample_out`.
- `sample_valid` is high for exactly one cycle, two cycles after the tick (cycle T+2). Latency is 2 cycles.
- Back-to-back ticks on consecutive cycles are legal. The pipeline then produces one valid per cycle with no stall.
- Reset asserted mid-note: on the next edge all outputs return to their reset values. An in-flight `sample_valid` is dropped.
- `active` and `level` are registered outputs and change the cycle after the tick.

## Structure
- Shared package `synth_pkg`:
  - `env_state_t` enum (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE).
  - `ENV_MAX = 16'hFFFF`.
  - `SAMPLE_W = 16`.
- One sub-module is natural: `env_scaler`, the 2-stage signed×unsigned multiply pipeline producing `sample_out` and `sample_valid`.
- The FSM and level arithmetic stay in `adsr_envelope`.

## Test plan
- Reset, then 10 ticks with `gate=0`, `sample_in=0x4000` → `level=0`, `active=0`, every `sample_out=0`, with `sample_valid` at tick+2.
- Gate rise with `attack_rate=0x4000`, `decay_rate=0x1000`, `sustain_level=0x8000`:
  - First tick: state only, `level` stays 0.
  - Following ticks: `level` 0x4000, 0x8000, 0xC000, 0xFFFF (enter DECAY), 0xEFFF … down to 0x8000 in SUSTAIN.
  - `sample_in=0x4000` at `level=0x8000` → `sample_out=0x2000`.
- Gate fall in SUSTAIN with `release_rate=0x3000`:
  - Fall tick holds `level`.
  - Then `level` 0x5000, 0x2000, 0 (IDLE, `active=0`).
- Retrigger during RELEASE at `level=0x5000` → ATTACK resumes from 0x5000 and never dips to 0.
- `sample_in=0x8000` at `level=0xFFFF` → `sample_out=0x8000`. Ticks on consecutive cycles → consecutive `sample_valid` pulses.
- Assert `Reset` for 1 cycle while in DECAY with a sample in flight → next cycle IDLE, `level=0`, `sample_valid=0`, `sample_out=0`.

Source files
------------

// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared synth constants and envelope state encoding
// Purpose: types and constants shared by the envelope stage and its scaler.
// Ports: none (package).
package synth_pkg;

  localparam int          SAMPLE_W = 16;
  localparam logic [15:0] ENV_MAX  = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

endpackage

// File: rtl/env_scaler.sv
// rtl/env_scaler.sv - two-stage signed sample x unsigned level multiply pipeline
// Purpose: captures the sample on a tick (stage 1), then registers the scaled
//          product and a one-cycle valid pulse (stage 2).
// Ports:
//   Clk, Reset      clock, synchronous active-high reset
//   sample_tick     capture strobe for sample_in
//   sample_in       signed sample, DW bits
//   level           unsigned envelope level, LW bits (already updated by the tick)
//   sample_out      signed scaled sample, DW bits
//   sample_valid    one-cycle pulse two cycles after the tick
module env_scaler
  import synth_pkg::*;
#(
  parameter int DW = SAMPLE_W,
  parameter int LW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          sample_tick,
  input  logic [DW-1:0] sample_in,
  input  logic [LW-1:0] level,
  output logic [DW-1:0] sample_out,
  output logic          sample_valid
);

  logic [DW-1:0]    s1_sample_q, s1_sample_d;
  logic             s1_valid_q, s1_valid_d;
  logic [DW-1:0]    out_q, out_d;
  logic             valid_q, valid_d;
  logic [DW+LW:0]   product;
  logic             unused_product_bits;

  // Zero-extend the level so it multiplies as a non-negative signed value;
  // the top LW-dropped slice is an arithmetic floor divide by 2^LW.
  assign product = $signed(s1_sample_q) * $signed({1'b0, level});
  assign unused_product_bits = ^{product[DW+LW], product[LW-1:0]};

  always_comb begin
    s1_sample_d = s1_sample_q;
    s1_valid_d  = sample_tick;
    out_d       = out_q;
    valid_d     = s1_valid_q;
    if (sample_tick) begin
      s1_sample_d = sample_in;
    end
    if (s1_valid_q) begin
      out_d = product[DW+LW-1:LW];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_sample_q <= '0;
      s1_valid_q  <= 1'b0;
      out_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      s1_sample_q <= s1_sample_d;
      s1_valid_q  <= s1_valid_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
    end
  end

  assign sample_out   = out_q;
  assign sample_valid = valid_q;

endmodule

// File: rtl/adsr_envelope.sv
// rtl/adsr_envelope.sv - ADSR amplitude envelope applied to a waveform sample
// Purpose: advances the ADSR state machine on each sample tick and scales the
//          incoming sample by the envelope level through env_scaler.
// Ports:
//   Clk, Reset        clock, synchronous active-high reset
//   sample_tick       audio-rate strobe, aligned with sample_in
//   gate              note held (1) / released (0), sampled on ticks
//   sample_in         signed waveform sample, DW bits
//   attack_rate       per-tick increment in ATTACK
//   decay_rate        per-tick decrement in DECAY
//   sustain_level     level held in SUSTAIN (tracked live)
//   release_rate      per-tick decrement in RELEASE
//   sample_out        signed scaled sample, DW bits
//   sample_valid      one-cycle pulse, sample_out is new (2 cycles after tick)
//   active            state is not IDLE (registered)
//   level             current envelope level (registered)
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int DW = SAMPLE_W,
  parameter int LW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          sample_tick,
  input  logic          gate,
  input  logic [DW-1:0] sample_in,
  input  logic [LW-1:0] attack_rate,
  input  logic [LW-1:0] decay_rate,
  input  logic [LW-1:0] sustain_level,
  input  logic [LW-1:0] release_rate,
  output logic [DW-1:0] sample_out,
  output logic          sample_valid,
  output logic          active,
  output logic [LW-1:0] level
);

  localparam logic [LW-1:0] LEVEL_MAX = {LW{1'b1}};

  env_state_t    state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic          gate_q, gate_d;
  logic          active_q, active_d;

  logic          rise, fall;
  logic [LW:0]   att_sum, dec_diff, rel_diff;

  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;

  // One extra bit: carry-out on the attack sum, borrow on the decrements.
  assign att_sum  = {1'b0, level_q} + {1'b0, attack_rate};
  assign dec_diff = {1'b0, level_q} - {1'b0, decay_rate};
  assign rel_diff = {1'b0, level_q} - {1'b0, release_rate};

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    gate_d  = gate_q;
    if (sample_tick) begin
      gate_d = gate;
      // Gate edges only change state; the level is held so a retrigger
      // resumes from wherever the envelope was (no click).
      if (rise) begin
        state_d = ATTACK;
      end else if (fall && (state_q == ATTACK || state_q == DECAY ||
                            state_q == SUSTAIN)) begin
        state_d = RELEASE;
      end else begin
        case (state_q)
          ATTACK: begin
            if (attack_rate == '0 || att_sum >= {1'b0, LEVEL_MAX}) begin
              level_d = LEVEL_MAX;
              state_d = DECAY;
            end else begin
              level_d = att_sum[LW-1:0];
            end
          end
          DECAY: begin
            if (decay_rate == '0 || dec_diff[LW] ||
                dec_diff[LW-1:0] <= sustain_level) begin
              level_d = sustain_level;
              state_d = SUSTAIN;
            end else begin
              level_d = dec_diff[LW-1:0];
            end
          end
          SUSTAIN: begin
            level_d = sustain_level;
          end
          RELEASE: begin
            if (release_rate == '0 || rel_diff[LW] || rel_diff[LW-1:0] == '0) begin
              level_d = '0;
              state_d = IDLE;
            end else begin
              level_d = rel_diff[LW-1:0];
            end
          end
          default: begin
            level_d = '0;
            state_d = IDLE;
          end
        endcase
      end
    end
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      level_q  <= '0;
      gate_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      gate_q   <= gate_d;
      active_q <= active_d;
    end
  end

  assign active = active_q;
  assign level  = level_q;

  env_scaler #(
    .DW (DW),
    .LW (LW)
  ) u_scaler (
    .Clk          (Clk),
    .Reset        (Reset),
    .sample_tick  (sample_tick),
    .sample_in    (sample_in),
    .level        (level_q),
    .sample_out   (sample_out),
    .sample_valid (sample_valid)
  );

endmodule

// File: tb/tb_adsr_envelope.sv
// tb/tb_adsr_envelope.sv - directed self-checking bench for adsr_envelope
module tb_adsr_envelope;

  logic        Clk;
  logic        Reset;
  logic        sample_tick;
  logic        gate;
  logic [15:0] sample_in;
  logic [15:0] attack_rate;
  logic [15:0] decay_rate;
  logic [15:0] sustain_level;
  logic [15:0] release_rate;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        active;
  logic [15:0] level;

  int checks   = 0;
  int failures = 0;

  adsr_envelope #(.DW(16), .LW(16)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .sample_tick   (sample_tick),
    .gate          (gate),
    .sample_in     (sample_in),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .active        (active),
    .level         (level)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: one tick, then check level/active after stage 1 and
  // the scaled sample when the valid pulse appears one cycle later.
  task automatic tick_chk(input string tag, input logic g, input logic [15:0] s,
                          input logic [15:0] exp_lvl, input logic exp_act,
                          input logic [15:0] exp_out);
    gate        = g;
    sample_in   = s;
    sample_tick = 1'b1;
    @(negedge Clk);
    sample_tick = 1'b0;
    chk({tag, ".level"}, level, exp_lvl);
    chk({tag, ".active"}, {15'd0, active}, {15'd0, exp_act});
    chk({tag, ".valid_early"}, {15'd0, sample_valid}, 16'd0);
    @(negedge Clk);
    chk({tag, ".valid"}, {15'd0, sample_valid}, 16'd1);
    chk({tag, ".out"}, sample_out, exp_out);
  endtask

  initial begin
    Reset         = 1'b1;
    sample_tick   = 1'b0;
    gate          = 1'b0;
    sample_in     = 16'h0000;
    attack_rate   = 16'h4000;
    decay_rate    = 16'h1000;
    sustain_level = 16'h8000;
    release_rate  = 16'h3000;
    repeat (2) @(negedge Clk);
    chk("rst.level", level, 16'h0000);
    chk("rst.active", {15'd0, active}, 16'd0);
    chk("rst.valid", {15'd0, sample_valid}, 16'd0);
    chk("rst.out", sample_out, 16'h0000);
    Reset = 1'b0;

    for (int i = 0; i < 10; i++) tick_chk("idle", 1'b0, 16'h4000, 16'h0000, 1'b0, 16'h0000);

    tick_chk("rise",  1'b1, 16'h4000, 16'h0000, 1'b1, 16'h0000);
    tick_chk("att1",  1'b1, 16'h4000, 16'h4000, 1'b1, 16'h1000);
    tick_chk("att2",  1'b1, 16'h4000, 16'h8000, 1'b1, 16'h2000);
    tick_chk("att3",  1'b1, 16'h4000, 16'hC000, 1'b1, 16'h3000);
    tick_chk("att4",  1'b1, 16'h4000, 16'hFFFF, 1'b1, 16'h3FFF);
    tick_chk("dec1",  1'b1, 16'h4000, 16'hEFFF, 1'b1, 16'h3BFF);
    tick_chk("dec2",  1'b1, 16'h4000, 16'hDFFF, 1'b1, 16'h37FF);
    tick_chk("dec3",  1'b1, 16'h4000, 16'hCFFF, 1'b1, 16'h33FF);
    tick_chk("dec4",  1'b1, 16'h4000, 16'hBFFF, 1'b1, 16'h2FFF);
    tick_chk("dec5",  1'b1, 16'h4000, 16'hAFFF, 1'b1, 16'h2BFF);
    tick_chk("dec6",  1'b1, 16'h4000, 16'h9FFF, 1'b1, 16'h27FF);
    tick_chk("dec7",  1'b1, 16'h4000, 16'h8FFF, 1'b1, 16'h23FF);
    tick_chk("dec8",  1'b1, 16'h4000, 16'h8000, 1'b1, 16'h2000);
    tick_chk("sus",   1'b1, 16'h4000, 16'h8000, 1'b1, 16'h2000);

    tick_chk("fall",  1'b0, 16'h4000, 16'h8000, 1'b1, 16'h2000);
    tick_chk("rel1",  1'b0, 16'h4000, 16'h5000, 1'b1, 16'h1400);
    tick_chk("rel2",  1'b0, 16'h4000, 16'h2000, 1'b1, 16'h0800);
    tick_chk("rel3",  1'b0, 16'h4000, 16'h0000, 1'b0, 16'h0000);
    tick_chk("idle2", 1'b0, 16'h4000, 16'h0000, 1'b0, 16'h0000);

    // decay_rate=0 jumps straight to sustain; sustain level tracks live edits
    decay_rate = 16'h0000;
    tick_chk("r2.rise", 1'b1, 16'h4000, 16'h0000, 1'b1, 16'h0000);
    tick_chk("r2.att1", 1'b1, 16'h4000, 16'h4000, 1'b1, 16'h1000);
    tick_chk("r2.att2", 1'b1, 16'h4000, 16'h8000, 1'b1, 16'h2000);
    tick_chk("r2.att3", 1'b1, 16'h4000, 16'hC000, 1'b1, 16'h3000);
    tick_chk("r2.att4", 1'b1, 16'h4000, 16'hFFFF, 1'b1, 16'h3FFF);
    tick_chk("r2.dec0", 1'b1, 16'h4000, 16'h8000, 1'b1, 16'h2000);
    sustain_level = 16'h6000;
    tick_chk("r2.live", 1'b1, 16'h4000, 16'h6000, 1'b1, 16'h1800);
    sustain_level = 16'h8000;
    tick_chk("r2.sus",  1'b1, 16'h4000, 16'h8000, 1'b1, 16'h2000);
    tick_chk("r2.fall", 1'b0, 16'h4000, 16'h8000, 1'b1, 16'h2000);
    tick_chk("r2.rel1", 1'b0, 16'h4000, 16'h5000, 1'b1, 16'h1400);

    // retrigger during release resumes from 0x5000
    tick_chk("rt.rise", 1'b1, 16'h4000, 16'h5000, 1'b1, 16'h1400);
    tick_chk("rt.att1", 1'b1, 16'h4000, 16'h9000, 1'b1, 16'h2400);
    tick_chk("rt.att2", 1'b1, 16'h4000, 16'hD000, 1'b1, 16'h3400);
    tick_chk("rt.att3", 1'b1, 16'h4000, 16'hFFFF, 1'b1, 16'h3FFF);

    // full-scale sustain, most negative sample stays 0x8000
    sustain_level = 16'hFFFF;
    decay_rate    = 16'h1000;
    tick_chk("fs.sus", 1'b1, 16'h8000, 16'hFFFF, 1'b1, 16'h8000);

    // back-to-back ticks give back-to-back valid pulses
    gate        = 1'b1;
    sample_in   = 16'h8000;
    sample_tick = 1'b1;
    @(negedge Clk);
    sample_in   = 16'h4000;
    chk("b2b.valid0", {15'd0, sample_valid}, 16'd0);
    @(negedge Clk);
    sample_in   = 16'h7FFF;
    chk("b2b.valid1", {15'd0, sample_valid}, 16'd1);
    chk("b2b.out1", sample_out, 16'h8000);
    @(negedge Clk);
    sample_tick = 1'b0;
    chk("b2b.valid2", {15'd0, sample_valid}, 16'd1);
    chk("b2b.out2", sample_out, 16'h3FFF);
    @(negedge Clk);
    chk("b2b.valid3", {15'd0, sample_valid}, 16'd1);
    chk("b2b.out3", sample_out, 16'h7FFE);
    @(negedge Clk);
    chk("b2b.valid4", {15'd0, sample_valid}, 16'd0);

    // walk into DECAY, then reset with a sample in flight
    tick_chk("rd.fall", 1'b0, 16'h4000, 16'hFFFF, 1'b1, 16'h3FFF);
    tick_chk("rd.rise", 1'b1, 16'h4000, 16'hFFFF, 1'b1, 16'h3FFF);
    tick_chk("rd.att",  1'b1, 16'h4000, 16'hFFFF, 1'b1, 16'h3FFF);
    sustain_level = 16'h1000;
    gate          = 1'b1;
    sample_in     = 16'h4000;
    sample_tick   = 1'b1;
    @(negedge Clk);
    sample_tick = 1'b0;
    chk("rd.dec.level", level, 16'hEFFF);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("rd.level", level, 16'h0000);
    chk("rd.active", {15'd0, active}, 16'd0);
    chk("rd.valid", {15'd0, sample_valid}, 16'd0);
    chk("rd.out", sample_out, 16'h0000);
    @(negedge Clk);
    chk("rd.valid_after", {15'd0, sample_valid}, 16'd0);
    tick_chk("rd.idle", 1'b0, 16'h4000, 16'h0000, 1'b0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
